// File: rtl/mat4_row2col_stream_if.sv
// Row-in / column-out handshake bundle for the 4x4 streaming transposer.
// The slave modport is the transposer's view; master is the producer/consumer side.
interface mat4_row2col_stream_if #(
    parameter int DW = 16,
    parameter int N  = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_row;
    logic            out_valid;
    logic            out_ready;
    logic [N*DW-1:0] out_col;
    logic            out_last;

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_col, out_last
    );

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_col, out_last
    );
endinterface

// File: rtl/mat4_row2col_stream.sv
// Streaming 4x4 transposer: rows in, columns out, ping-pong banks for one beat/cycle.
// Optional XPOSE_FRAME_CNT_EN adds frame_cnt (completed matrices) and sticky overrun.
module mat4_row2col_stream #(
    parameter int DW = 16,
    parameter int N  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mat4_row2col_stream_if.slave s
`ifdef XPOSE_FRAME_CNT_EN
    ,
    output logic [7:0]           frame_cnt,
    output logic                 overrun
`endif
);

    logic [DW-1:0]   bank_r [2][N][N];
    logic [1:0]      full_r;
    logic            wb_r;
    logic            rb_r;
    logic [1:0]      wr_r;
    logic [1:0]      rc_r;

    logic            wr_fire_s;
    logic            rd_fire_s;
    logic            wr_done_s;
    logic            rd_done_s;
    logic [1:0]      set_mask_s;
    logic [1:0]      clr_mask_s;
    logic [N*DW-1:0] col_s;

    assign wr_fire_s   = s.in_valid & ~full_r[wb_r];
    assign rd_fire_s   = full_r[rb_r] & s.out_ready;
    assign wr_done_s   = wr_fire_s & (wr_r == 2'd3);
    assign rd_done_s   = rd_fire_s & (rc_r == 2'd3);

    assign s.in_ready  = ~full_r[wb_r];
    assign s.out_valid = full_r[rb_r];
    assign s.out_last  = full_r[rb_r] & (rc_r == 2'd3);
    assign s.out_col   = col_s;

    // Gather column rc of the read bank; row 0 lands in the top element slot.
    always_comb begin
        col_s = {(N*DW){1'b0}};
        for (int r = 0; r < N; r++) begin
            col_s[(N-1-r)*DW +: DW] = bank_r[rb_r][2'(r)][rc_r];
        end
    end

    // Per-bank full flag set/clear masks; write and read always address different banks.
    always_comb begin
        set_mask_s = 2'b00;
        clr_mask_s = 2'b00;
        if (wr_done_s) begin
            set_mask_s[wb_r] = 1'b1;
        end else begin
            set_mask_s = 2'b00;
        end
        if (rd_done_s) begin
            clr_mask_s[rb_r] = 1'b1;
        end else begin
            clr_mask_s = 2'b00;
        end
    end

    // Bank storage: an accepted row is split into its N elements.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        bank_r[b][r][c] <= {DW{1'b0}};
                    end
                end
            end
        end else if (wr_fire_s) begin
            for (int c = 0; c < N; c++) begin
                bank_r[wb_r][wr_r][2'(c)] <= s.in_row[(N-1-c)*DW +: DW];
            end
        end
    end

    // Bank flags and write/read pointers; a released bank is writable only next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_r <= 2'b00;
            wb_r   <= 1'b0;
            rb_r   <= 1'b0;
            wr_r   <= 2'd0;
            rc_r   <= 2'd0;
        end else begin
            full_r <= (full_r | set_mask_s) & ~clr_mask_s;
            if (wr_fire_s) begin
                wr_r <= wr_r + 2'd1;
            end
            if (wr_done_s) begin
                wb_r <= ~wb_r;
            end
            if (rd_fire_s) begin
                rc_r <= rc_r + 2'd1;
            end
            if (rd_done_s) begin
                rb_r <= ~rb_r;
            end
        end
    end

`ifdef XPOSE_FRAME_CNT_EN
    // Completed-matrix counter (wraps) and sticky flag for rows offered while full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= 8'd0;
            overrun   <= 1'b0;
        end else begin
            if (rd_done_s) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (s.in_valid & full_r[wb_r]) begin
                overrun <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mat4_row2col_stream.sv
// Self-checking bench for mat4_row2col_stream: random rows against a queue-based
// transpose model; XPOSE_FRAME_CNT_EN enables the frame counter / overrun scenarios.
module tb_mat4_row2col_stream;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mat4_row2col_stream_if #(.DW(16), .N(4)) bus ();

`ifdef XPOSE_FRAME_CNT_EN
    logic [7:0] frame_cnt;
    logic       overrun;
`endif

    mat4_row2col_stream #(.DW(16), .N(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s         (bus)
`ifdef XPOSE_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt),
        .overrun   (overrun)
`endif
    );

    // Reference model: rows to send, rows of the matrix being filled, columns owed.
    logic [63:0] tx_q[$];
    logic [63:0] rows_q[$];
    logic [63:0] cols_q[$];
    bit          last_q[$];
    int          exp_frames = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    // Matrices held = complete matrices not yet fully read; at most two fit.
    function automatic bit exp_ready();
        return ((cols_q.size() + 3) / 4) < 2;
    endfunction

    function automatic bit exp_valid();
        return cols_q.size() > 0;
    endfunction

    task automatic present(input bit ordy);
        bus.in_valid  = (tx_q.size() > 0);
        bus.in_row    = (tx_q.size() > 0) ? tx_q[0] : 64'd0;
        bus.out_ready = ordy;
    endtask

    // Advance one clock and update the model with whatever handshakes should fire.
    task automatic tick();
        bit          wf;
        bit          rf;
        logic [63:0] row;
        logic [63:0] col;
        wf  = (bus.in_valid === 1'b1) && exp_ready();
        rf  = (bus.out_ready === 1'b1) && exp_valid();
        row = bus.in_row;
        @(posedge clk);
        #1;
        if (rf) begin
            if (last_q[0]) exp_frames = (exp_frames + 1) % 256;
            void'(cols_q.pop_front());
            void'(last_q.pop_front());
        end
        if (wf) begin
            void'(tx_q.pop_front());
            rows_q.push_back(row);
            if (rows_q.size() == 4) begin
                for (int c = 0; c < 4; c++) begin
                    col = 64'd0;
                    for (int r = 0; r < 4; r++) col[(3-r)*16 +: 16] = rows_q[r][(3-c)*16 +: 16];
                    cols_q.push_back(col);
                    last_q.push_back(c == 3);
                end
                rows_q.delete();
            end
        end
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_row    = 64'd0;
        bus.out_ready = 1'b0;
        tx_q.delete(); rows_q.delete(); cols_q.delete(); last_q.delete();
        exp_frames = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_row    = 64'd0;
        bus.out_ready = 1'b0;
        #12;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.out_col !== 64'd0) begin n_err++; $display("FAIL reset_out_col got=%h exp=0", bus.out_col); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [63:0] exp_tab [4] = '{64'h0000_0010_0020_0030, 64'h0001_0011_0021_0031,
                                     64'h0002_0012_0022_0032, 64'h0003_0013_0023_0033};
        for (int r = 0; r < 4; r++) tx_q.push_back({16'(r*16), 16'(r*16+1), 16'(r*16+2), 16'(r*16+3)});
        for (int cyc = 0; cyc < 10; cyc++) begin
            present(1'b1);
            n_cmp++; if (bus.out_valid !== (cyc >= 4 && cyc < 8)) begin n_err++; $display("FAIL single_valid cyc=%0d got=%b", cyc, bus.out_valid); end
            if (cyc >= 4 && cyc < 8) begin
                n_cmp++; if (bus.out_col !== exp_tab[cyc-4]) begin n_err++; $display("FAIL single_col cyc=%0d got=%h exp=%h", cyc, bus.out_col, exp_tab[cyc-4]); end
                n_cmp++; if (bus.out_last !== (cyc == 7)) begin n_err++; $display("FAIL single_last cyc=%0d got=%b", cyc, bus.out_last); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        for (int i = 0; i < 32; i++) tx_q.push_back({$urandom, $urandom});
        for (int cyc = 0; cyc < 40; cyc++) begin
            present(1'b1);
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", cyc, bus.in_ready); end
            if (cyc >= 4 && cyc < 36) begin
                n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_bubble cyc=%0d got=%b exp=1", cyc, bus.out_valid); end
            end
            if (exp_valid()) begin
                n_cmp++; if (bus.out_col !== cols_q[0]) begin n_err++; $display("FAIL b2b_col cyc=%0d got=%h exp=%h", cyc, bus.out_col, cols_q[0]); end
                n_cmp++; if (bus.out_last !== last_q[0]) begin n_err++; $display("FAIL b2b_last cyc=%0d got=%b exp=%b", cyc, bus.out_last, last_q[0]); end
            end
            if (bus.out_valid === 1'b1) got++;
            tick();
        end
        n_cmp++; if (got != 32) begin n_err++; $display("FAIL b2b_count got=%0d exp=32", got); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 9; i++) tx_q.push_back({$urandom, $urandom});
        for (int cyc = 0; cyc < 12; cyc++) begin
            present(1'b0);
            n_cmp++; if (bus.in_ready !== (cyc < 8)) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, cyc < 8); end
            tick();
        end
        n_cmp++; if (tx_q.size() != 1) begin n_err++; $display("FAIL bp_row9_held got=%0d exp=1", tx_q.size()); end
        for (int i = 0; i < 3; i++) tx_q.push_back({$urandom, $urandom});
        for (int cyc = 0; cyc < 30 && (tx_q.size() > 0 || exp_valid()); cyc++) begin
            present(1'b1);
            n_cmp++; if (bus.in_ready !== exp_ready()) begin n_err++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, exp_ready()); end
            n_cmp++; if (bus.out_valid !== exp_valid()) begin n_err++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, exp_valid()); end
            if (exp_valid()) begin
                n_cmp++; if (bus.out_col !== cols_q[0]) begin n_err++; $display("FAIL bp_col cyc=%0d got=%h exp=%h", cyc, bus.out_col, cols_q[0]); end
                n_cmp++; if (bus.out_last !== last_q[0]) begin n_err++; $display("FAIL bp_last cyc=%0d got=%b exp=%b", cyc, bus.out_last, last_q[0]); end
            end
            tick();
        end
        n_cmp++; if (tx_q.size() != 0 || exp_valid()) begin n_err++; $display("FAIL bp_timeout left=%0d cols=%0d exp=0", tx_q.size(), cols_q.size()); end
    endtask

    task automatic test_stall();
        logic [63:0] prev_col  = 64'd0;
        bit          prev_last = 1'b0;
        bit          stalled   = 1'b0;
        bit          ordy;
        for (int i = 0; i < 8; i++) tx_q.push_back({$urandom, $urandom});
        for (int cyc = 0; cyc < 60 && (tx_q.size() > 0 || exp_valid()); cyc++) begin
            ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
            present(ordy);
            if (stalled) begin
                n_cmp++; if (bus.out_col !== prev_col) begin n_err++; $display("FAIL stall_hold_col cyc=%0d got=%h exp=%h", cyc, bus.out_col, prev_col); end
                n_cmp++; if (bus.out_last !== prev_last) begin n_err++; $display("FAIL stall_hold_last cyc=%0d got=%b exp=%b", cyc, bus.out_last, prev_last); end
            end
            n_cmp++; if (bus.out_valid !== exp_valid()) begin n_err++; $display("FAIL stall_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, exp_valid()); end
            if (exp_valid()) begin
                n_cmp++; if (bus.out_col !== cols_q[0]) begin n_err++; $display("FAIL stall_col cyc=%0d got=%h exp=%h", cyc, bus.out_col, cols_q[0]); end
                n_cmp++; if (bus.out_last !== last_q[0]) begin n_err++; $display("FAIL stall_last cyc=%0d got=%b exp=%b", cyc, bus.out_last, last_q[0]); end
            end
            stalled   = exp_valid() && !ordy;
            prev_col  = bus.out_col;
            prev_last = bus.out_last;
            tick();
        end
        n_cmp++; if (tx_q.size() != 0 || exp_valid()) begin n_err++; $display("FAIL stall_timeout left=%0d cols=%0d exp=0", tx_q.size(), cols_q.size()); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) tx_q.push_back({$urandom, $urandom});
        for (int cyc = 0; cyc < 6; cyc++) begin
            present(cyc >= 4);
            tick();
        end
        n_cmp++; if (bus.out_col !== cols_q[0]) begin n_err++; $display("FAIL rmid_col2 got=%h exp=%h", bus.out_col, cols_q[0]); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready got=%b exp=1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.out_col !== 64'd0) begin n_err++; $display("FAIL rmid_out_col got=%h exp=0", bus.out_col); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL rmid_out_last got=%b exp=0", bus.out_last); end
        do_reset();
        for (int cyc = 0; cyc < 3; cyc++) begin
            present(1'b1);
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale cyc=%0d got=%b exp=0", cyc, bus.out_valid); end
            tick();
        end
        for (int i = 0; i < 4; i++) tx_q.push_back({$urandom, $urandom});
        for (int cyc = 0; cyc < 20 && (tx_q.size() > 0 || exp_valid()); cyc++) begin
            present(1'b1);
            n_cmp++; if (bus.out_valid !== exp_valid()) begin n_err++; $display("FAIL rmid_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, exp_valid()); end
            if (exp_valid()) begin
                n_cmp++; if (bus.out_col !== cols_q[0]) begin n_err++; $display("FAIL rmid_col cyc=%0d got=%h exp=%h", cyc, bus.out_col, cols_q[0]); end
            end
            tick();
        end
        n_cmp++; if (tx_q.size() != 0 || exp_valid()) begin n_err++; $display("FAIL rmid_timeout left=%0d cols=%0d exp=0", tx_q.size(), cols_q.size()); end
    endtask

`ifdef XPOSE_FRAME_CNT_EN
    task automatic test_frame_cnt();
        do_reset();
        n_cmp++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL fc_reset got=%0d exp=0", frame_cnt); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_reset got=%b exp=0", overrun); end
        for (int i = 0; i < 1024; i++) tx_q.push_back({$urandom, $urandom});
        for (int cyc = 0; cyc < 1100 && (tx_q.size() > 0 || exp_valid()); cyc++) begin
            present(1'b1);
            tick();
            n_cmp++; if (frame_cnt !== 8'(exp_frames)) begin n_err++; $display("FAIL fc_count cyc=%0d got=%0d exp=%0d", cyc, frame_cnt, exp_frames); end
        end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL fc_wrap got=%0d exp=0", frame_cnt); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clean got=%b exp=0", overrun); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 12; i++) tx_q.push_back({$urandom, $urandom});
        for (int cyc = 0; cyc < 8; cyc++) begin
            present(1'b0);
            tick();
        end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early got=%b exp=0", overrun); end
        present(1'b0);
        tick();
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        for (int cyc = 0; cyc < 30 && (tx_q.size() > 0 || exp_valid()); cyc++) begin
            present(1'b1);
            tick();
        end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        do_reset();
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_stall();
        test_reset_mid();
`ifdef XPOSE_FRAME_CNT_EN
        test_frame_cnt();
        test_overrun();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
